dma_io_sink: RTL and testbench
==============================

Name: dma_io_sink

Overview:
- Memory-to-IO DMA peripheral: the consuming end of the DREQ/DACK channel, where the disk and keypad are the producing ends.
- Requests service on its DREQ line and captures bytes from DB when the DMA controller acknowledges with an IO-write strobe.
- Buffers received bytes in a FIFO and drains them to a paced ready/valid output port (display/printer style).
- Counts a programmed block length and signals completion.

Parameters:
DEPTH, 8, FIFO depth in bytes (power of 2, >=2)
DRAIN_DIV, 4, minimum CLK cycles between successive output pops (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
ENABLE  input  1  arm the channel; rising edge starts a block
LEN  input  8  block length in bytes, sampled on ENABLE rise; 0 means 256
DB  input  8  shared data bus; this block never drives it
CB  input  4  control bus: [0] MEMR, [1] MEMW, [2] IOR, [3] IOW, active-high
DACK  input  1  DMA acknowledge for this channel
DREQ  output  1  DMA request
OUT_DATA  output  8  head-of-FIFO byte
OUT_VALID  output  1  OUT_DATA valid
OUT_READY  input  1  consumer accepts OUT_DATA when high with OUT_VALID
DONE  output  1  one-cycle pulse when the final byte of the block is captured
OVF  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- Reset (RST_N low, asynchronous):
  - DREQ=0, OUT_VALID=0, OUT_DATA=8'h00, DONE=0, OVF=0.
  - FIFO empty, byte counter=0, pacing counter=0, state=IDLE.
  - Reset mid-block discards all buffered data and the remaining count.
- Push condition: DACK && CB[3] at a rising CLK edge. Only then is DB captured. AB is ignored; the channel is selected by DACK.
- Pop condition: OUT_VALID && OUT_READY at a rising CLK edge.
- FSM IDLE:
  - DREQ=0.
  - On an ENABLE 0->1 edge (ENABLE registered, edge compared to the previous cycle): load remaining=LEN (0 -> 256), go to REQ.
- FSM REQ:
  - DREQ=1 while the FIFO has at least 2 free entries.
  - DREQ drops combinationally off the registered count when free < 2. This leaves margin for one in-flight push.
  - On a push, go to XFER.
- FSM XFER:
  - Each push writes the FIFO and decrements remaining.
  - DREQ follows the same free-space rule as in REQ.
  - When DACK falls, return to REQ.
  - When the push that makes remaining 0 occurs: pulse DONE for one cycle, DREQ=0 in the next cycle, go to DONE_WAIT.
- FSM DONE_WAIT:
  - DREQ=0.
  - Return to IDLE when ENABLE=0. A new block requires a fresh ENABLE rise.
- ENABLE deasserted in REQ or XFER:
  - Go to IDLE, DREQ=0 next cycle.
  - Remaining count is discarded; buffered bytes still drain.
  - A push in the same cycle is still captured.
- Push outside REQ/XFER (stray DACK&IOW): ignored, no FIFO write, no counter change.
- Push while the FIFO is full and no pop in the same cycle: byte dropped, OVF<=1. OVF is cleared only by reset.
- Simultaneous push and pop:
  - The pop frees its slot first, so a push on a full FIFO with a concurrent pop succeeds and the count is unchanged.
  - On an empty FIFO a push with no pop gives OUT_VALID=1 on the next cycle (1-cycle latency DB->OUT_DATA).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Pacing:
  - After each pop the pacing counter loads DRAIN_DIV-1.
  - OUT_VALID is forced 0 while the counter is non-zero; it decrements each cycle.
  - With DRAIN_DIV=1 back-to-back pops are possible.
- OUT_DATA always shows the head entry registered. It holds its last value when empty.
- CB[0], CB[1], CB[2] are ignored. Concurrent IOW and IOR with DACK is treated as IOW.

Optional Feature:
- Macro: DMA_IO_SINK_PARITY_EN.
- Defined:
  - Extra output OUT_PAR (1 bit) = odd parity of OUT_DATA, stored per FIFO entry at push time. The FIFO is 9 bits wide.
  - Extra sticky output PERR: set when OUT_PAR stored does not equal parity recomputed at pop. Cleared by reset.
- Undefined: neither port exists, and the FIFO is 8 bits wide.

Test Plan:
- Reset then ENABLE rise with LEN=3; DMA gives DACK+IOW for 3 cycles with DB=8'hA1, 8'hB2, 8'hC3 -> DONE pulses in the cycle after the 3rd push, DREQ=0, OUT_DATA emits A1, B2, C3 in order with OUT_READY=1, pops spaced 4 cycles apart.
- LEN=12, DEPTH=8, OUT_READY=0 -> DREQ drops once count reaches 7. A forced push at count 8 sets OVF=1 and leaves FIFO contents unchanged.
- FIFO full with OUT_READY=1 and a simultaneous push -> count stays 8, no OVF, new byte appears last.
- RST_N pulsed low mid-block after 2 of 5 bytes -> all outputs return to reset values immediately; a new ENABLE rise restarts with a fresh LEN.
- DACK+IOW while in IDLE with DB=8'h55 -> no FIFO write, OUT_VALID stays 0.
- LEN=0 -> exactly 256 bytes accepted before DONE.

Source files
------------

// File: rtl/dma_io_sink.sv
// Memory-to-IO DMA sink: requests on DREQ, captures DB on DACK+IOW into a FIFO,
// and drains it to a paced ready/valid port. Optional parity: DMA_IO_SINK_PARITY_EN.
module dma_io_sink #(
  parameter int DEPTH     = 8,
  parameter int DRAIN_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic [7:0] LEN,
  input  logic [7:0] DB,
  input  logic [3:0] CB,
  input  logic       DACK,
  output logic       DREQ,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       DONE,
  output logic       OVF
`ifdef DMA_IO_SINK_PARITY_EN
  ,
  output logic       OUT_PAR,
  output logic       PERR
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
`ifdef DMA_IO_SINK_PARITY_EN
  localparam int W = 9;
  // Parity bit of the reset head must agree with OUT_DATA = 0.
  localparam logic [W-1:0] HEAD_RST = 9'h100;
`else
  localparam int W = 8;
  localparam logic [W-1:0] HEAD_RST = 8'h00;
`endif

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE_WAIT} state_t;

  state_t        state, state_nx;
  logic          enable_q;
  logic [8:0]    remaining, remaining_nx;
  logic          done_nx;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [AW:0]   count, count_after_pop;
  logic [PW-1:0] pace;
  logic [W-1:0]  head_q, din;
  logic          done_q, ovf_q;
  logic          active, push, pop, full, accept, wr_en, drop, final_push;
  logic          unused_cb;

  assign unused_cb = ^CB[2:0];

`ifdef DMA_IO_SINK_PARITY_EN
  assign din = {~^DB, DB};
`else
  assign din = DB;
`endif

  assign active     = (state == REQ) || (state == XFER);
  assign push       = DACK & CB[3];
  assign OUT_VALID  = (count != '0) && (pace == '0);
  assign pop        = OUT_VALID & OUT_READY;
  assign full       = (count == (AW+1)'(DEPTH));
  assign accept     = push & active;
  // A concurrent pop frees its slot before the write lands.
  assign wr_en      = accept & (~full | pop);
  assign drop       = accept & full & ~pop;
  assign final_push = accept & (remaining == 9'd1);

  assign count_after_pop = count - (AW+1)'(pop);
  assign rd_ptr_nx       = rd_ptr + AW'(pop);

  // Keep one slot of margin for a push already in flight when DREQ falls.
  assign DREQ     = active && (count <= (AW+1)'(DEPTH-2));
  assign OUT_DATA = head_q[7:0];
  assign DONE     = done_q;
  assign OVF      = ovf_q;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    done_nx      = 1'b0;
    case (state)
      IDLE: if (ENABLE && !enable_q) begin
        state_nx     = REQ;
        remaining_nx = (LEN == 8'd0) ? 9'd256 : {1'b0, LEN};
      end
      REQ, XFER: begin
        // Dropped bytes still count: the bus transfer happened.
        if (accept)     remaining_nx = remaining - 9'd1;
        if (final_push) done_nx      = 1'b1;
        if (!ENABLE) begin
          state_nx     = IDLE;
          remaining_nx = '0;
        end
        else if (final_push)                 state_nx = DONE_WAIT;
        else if (state == REQ && accept)     state_nx = XFER;
        else if (state == XFER && !DACK)     state_nx = REQ;
      end
      DONE_WAIT: if (!ENABLE) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK)
    if (wr_en) mem[wr_ptr] <= din;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      enable_q  <= 1'b0;
      remaining <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pace      <= '0;
      head_q    <= HEAD_RST;
    end else begin
      state     <= state_nx;
      enable_q  <= ENABLE;
      remaining <= remaining_nx;
      done_q    <= done_nx;
      if (drop)  ovf_q  <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_ptr_nx;
      count  <= count_after_pop + (AW+1)'(wr_en);
      if (pop)              pace <= PW'(DRAIN_DIV - 1);
      else if (pace != '0)  pace <= pace - PW'(1);
      // Head register shows the post-edge head; holds when the FIFO empties.
      if (count_after_pop != '0) head_q <= mem[rd_ptr_nx];
      else if (wr_en)            head_q <= din;
    end
  end

`ifdef DMA_IO_SINK_PARITY_EN
  logic perr_q;
  assign OUT_PAR = head_q[8];
  assign PERR    = perr_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                   perr_q <= 1'b0;
    else if (pop && (head_q[8] != ~^head_q[7:0])) perr_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dma_io_sink.sv
// Bench for dma_io_sink: directed vector table, corner sequences, and a
// randomized run against a queue-based reference model.
module tb_dma_io_sink;
  localparam int DEPTH = 8, DRAIN_DIV = 4;

  logic       CLK = 1'b0;
  logic       RST_N, ENABLE, DACK, OUT_READY;
  logic [7:0] LEN, DB;
  logic [3:0] CB;
  logic       DREQ, OUT_VALID, DONE, OVF;
  logic [7:0] OUT_DATA;
`ifdef DMA_IO_SINK_PARITY_EN
  logic OUT_PAR, PERR;
`endif

  always #5 CLK = ~CLK;

  dma_io_sink #(.DEPTH(DEPTH), .DRAIN_DIV(DRAIN_DIV)) dut (
    .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .LEN(LEN), .DB(DB), .CB(CB),
    .DACK(DACK), .DREQ(DREQ), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .DONE(DONE), .OVF(OVF)
`ifdef DMA_IO_SINK_PARITY_EN
    , .OUT_PAR(OUT_PAR), .PERR(PERR)
`endif
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic en, input logic [7:0] len, input logic [7:0] db,
                       input logic dack, input logic [3:0] cb, input logic rdy);
    ENABLE = en; LEN = len; DB = db; DACK = dack; CB = cb; OUT_READY = rdy;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    RST_N = 1'b0;
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  typedef struct {
    logic       en;  logic [7:0] len; logic [7:0] db;
    logic       dack; logic [3:0] cb; logic rdy;
    logic       dreq; logic vld; logic [7:0] data; logic done; logic ovf;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [7:0] len, input logic [7:0] db,
                              input logic dack, input logic [3:0] cb, input logic rdy,
                              input logic dreq, input logic vld, input logic [7:0] data,
                              input logic done, input logic ovf);
    vec_t v;
    v.en = en; v.len = len; v.db = db; v.dack = dack; v.cb = cb; v.rdy = rdy;
    v.dreq = dreq; v.vld = vld; v.data = data; v.done = done; v.ovf = ovf;
    return v;
  endfunction

  // Reference model state
  int         ph, rem, pace;
  logic [7:0] q[$];
  logic [7:0] last;
  logic       m_ovf, m_done, en_prev;

  initial begin
    vec_t       tbl[14];
    logic [7:0] exp_drain[8];
    int         w, pushes, cyc;
    logic       e_dreq, e_vld, pop_m, push_m, en_r;
    logic [7:0] e_data;

    // LEN=3 block, pops paced 4 cycles apart, then stray pushes in IDLE.
    tbl[0]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  1, 0, 8'h00, 0, 0);
    tbl[1]  = mk(1, 3, 8'hA1, 1, 4'h8, 1,  1, 1, 8'hA1, 0, 0);
    tbl[2]  = mk(1, 3, 8'hB2, 1, 4'hC, 1,  1, 0, 8'hB2, 0, 0);
    tbl[3]  = mk(1, 3, 8'hC3, 1, 4'h8, 1,  0, 0, 8'hB2, 1, 0);
    tbl[4]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hB2, 0, 0);
    tbl[5]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 1, 8'hB2, 0, 0);
    tbl[6]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hC3, 0, 0);
    tbl[7]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hC3, 0, 0);
    tbl[8]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hC3, 0, 0);
    tbl[9]  = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 1, 8'hC3, 0, 0);
    tbl[10] = mk(1, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hC3, 0, 0);
    tbl[11] = mk(0, 3, 8'h00, 0, 4'h0, 1,  0, 0, 8'hC3, 0, 0);
    tbl[12] = mk(0, 3, 8'h55, 1, 4'h8, 1,  0, 0, 8'hC3, 0, 0);
    tbl[13] = mk(0, 3, 8'h55, 1, 4'hF, 1,  0, 0, 8'hC3, 0, 0);

    // Reset state
    drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    RST_N = 1'b0;
    tick();
    chk("rst_dreq", DREQ, 0);   chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0); chk("rst_done", DONE, 0); chk("rst_ovf", OVF, 0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].len, tbl[i].db, tbl[i].dack, tbl[i].cb, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_dreq", i), DREQ, tbl[i].dreq);
      chk($sformatf("vec%0d_valid", i), OUT_VALID, tbl[i].vld);
      chk($sformatf("vec%0d_data", i), OUT_DATA, tbl[i].data);
      chk($sformatf("vec%0d_done", i), DONE, tbl[i].done);
      chk($sformatf("vec%0d_ovf", i), OVF, tbl[i].ovf);
    end

    // Fill to full with consumer stalled, simultaneous push/pop, overflow drop.
    do_reset();
    drive(1, 8'd12, 8'd0, 0, 4'h0, 0);
    tick();
    for (int i = 1; i <= 6; i++) begin
      drive(1, 8'd12, 8'(i), 1, 4'h8, 0);
      tick();
    end
    chk("fill6_dreq", DREQ, 1);
    drive(1, 8'd12, 8'd7, 1, 4'h8, 0);
    tick();
    chk("fill7_dreq_drop", DREQ, 0);
    drive(1, 8'd12, 8'd8, 1, 4'h8, 0);
    tick();
    chk("full_no_ovf", OVF, 0);
    chk("full_head", OUT_DATA, 8'h01);
    chk("full_valid", OUT_VALID, 1);
    drive(1, 8'd12, 8'h99, 1, 4'h8, 1);
    tick();
    chk("simul_no_ovf", OVF, 0);
    chk("simul_head", OUT_DATA, 8'h02);
    drive(1, 8'd12, 8'h77, 1, 4'h8, 0);
    tick();
    chk("drop_ovf", OVF, 1);
    exp_drain = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h99};
    drive(1, 8'd12, 8'h00, 0, 4'h0, 1);
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (!OUT_VALID && w < 20) begin tick(); w++; end
      chk($sformatf("drain%0d_valid", k), OUT_VALID, 1);
      chk($sformatf("drain%0d_data", k), OUT_DATA, exp_drain[k]);
      if (k > 0) chk($sformatf("drain%0d_gap", k), w, DRAIN_DIV - 1);
      tick();
    end
    chk("drained_empty", OUT_VALID, 0);
    chk("drained_hold", OUT_DATA, 8'h99);
    chk("ovf_sticky", OVF, 1);

    // Reset mid-block discards data and count.
    do_reset();
    drive(1, 8'd5, 8'h00, 0, 4'h0, 0);
    tick();
    drive(1, 8'd5, 8'hAA, 1, 4'h8, 0); tick();
    drive(1, 8'd5, 8'hBB, 1, 4'h8, 0); tick();
    drive(1, 8'd5, 8'h00, 0, 4'h0, 0);
    chk("pre_rst_valid", OUT_VALID, 1);
    chk("pre_rst_dreq", DREQ, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mid_rst_dreq", DREQ, 0);   chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_data", OUT_DATA, 0); chk("mid_rst_done", DONE, 0);
    ENABLE = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    chk("post_rst_idle_dreq", DREQ, 0);
    drive(1, 8'd2, 8'h00, 0, 4'h0, 0); tick();
    drive(1, 8'd2, 8'h11, 1, 4'h8, 0); tick();
    chk("restart_done0", DONE, 0);
    drive(1, 8'd2, 8'h22, 1, 4'h8, 0); tick();
    chk("restart_done1", DONE, 1);
    chk("restart_dreq", DREQ, 0);
    chk("restart_head", OUT_DATA, 8'h11);
    drive(0, 8'd0, 8'h00, 0, 4'h0, 0); tick();

    // LEN=0 means 256 bytes.
    do_reset();
    drive(1, 8'd0, 8'h00, 0, 4'h0, 1);
    tick();
    pushes = 0; cyc = 0;
    while (!DONE && cyc < 4000) begin
      if (DREQ) begin drive(1, 8'd0, 8'(pushes), 1, 4'h8, 1); pushes++; end
      else drive(1, 8'd0, 8'h00, 0, 4'h0, 1);
      tick();
      cyc++;
    end
    chk("len0_done", DONE, 1);
    chk("len0_pushes", pushes, 256);
    chk("len0_no_ovf", OVF, 0);
    drive(0, 8'd0, 8'h00, 0, 4'h0, 1);
    tick();

    // Randomized run against the reference model.
    do_reset();
    ph = 0; rem = 0; pace = 0; q = {}; last = 8'h00;
    m_ovf = 0; m_done = 0; en_prev = 0; en_r = 0;
    for (int c = 0; c < 5000; c++) begin
      e_dreq = (ph == 1) && (DEPTH - q.size() >= 2);
      e_vld  = (q.size() > 0) && (pace == 0);
      e_data = (q.size() > 0) ? q[0] : last;
      chk("rnd_dreq", DREQ, e_dreq);
      chk("rnd_valid", OUT_VALID, e_vld);
      chk("rnd_data", OUT_DATA, e_data);
      chk("rnd_done", DONE, m_done);
      chk("rnd_ovf", OVF, m_ovf);
`ifdef DMA_IO_SINK_PARITY_EN
      chk("rnd_par", OUT_PAR, ~^OUT_DATA);
      chk("rnd_perr", PERR, 0);
`endif
      if ($urandom_range(0, 63) == 0) en_r = ~en_r;
      drive(en_r, 8'($urandom_range(0, 20)), 8'($urandom), 1'b0, 4'($urandom),
            1'($urandom_range(0, 1)));
      DACK = e_dreq ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);

      pop_m  = e_vld && OUT_READY;
      push_m = DACK && CB[3];
      m_done = 0;
      if (pop_m) void'(q.pop_front());
      if (ph == 1 && push_m) begin
        if (q.size() < DEPTH) q.push_back(DB);
        else m_ovf = 1;
        rem--;
        if (rem == 0) m_done = 1;
      end
      if (pop_m) pace = DRAIN_DIV - 1;
      else if (pace > 0) pace--;
      case (ph)
        0: if (ENABLE && !en_prev) begin ph = 1; rem = (LEN == 0) ? 256 : int'(LEN); end
        1: if (!ENABLE) ph = 0; else if (rem == 0) ph = 2;
        default: if (!ENABLE) ph = 0;
      endcase
      en_prev = ENABLE;
      if (q.size() > 0) last = q[0];
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
